// File: rtl/front_panel_pkg.sv
// Shared types and speed codes for the front-panel controller.
// Speed codes match the clock controller's mode[2:0] encoding.
package front_panel_pkg;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [2:0] SPEED_10HZ   = 3'd1;
  localparam logic [2:0] SPEED_100HZ  = 3'd2;
  localparam logic [2:0] SPEED_1KHZ   = 3'd3;
  localparam logic [2:0] SPEED_10KHZ  = 3'd4;
  localparam logic [2:0] SPEED_100KHZ = 3'd5;
  localparam logic [2:0] SPEED_1MHZ   = 3'd6;
  localparam logic [2:0] SPEED_TURBO  = 3'd7;

  localparam logic [2:0] SPEED_MIN = SPEED_10HZ;
  localparam logic [2:0] SPEED_MAX = SPEED_TURBO;

  localparam int BTN_STEP = 0;
  localparam int BTN_RUN  = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DOWN = 3;
  localparam int NUM_BTN  = 4;

  // Opposing presses in one cycle cancel out.
  function automatic logic [2:0] speed_next(
    input logic [2:0] cur,
    input logic       up,
    input logic       dn
  );
    logic [2:0] nxt;
    nxt = cur;
    unique case (1'b1)
      (up && !dn && cur != SPEED_MAX): nxt = cur + 3'd1;
      (dn && !up && cur != SPEED_MIN): nxt = cur - 3'd1;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/front_panel_ctrl_if.sv
// Front-panel bundle: raw buttons in, clock-controller mode/step out.
// slave = controller side, master = panel/bench side.
interface front_panel_ctrl_if;
  logic       btn_step_raw;
  logic       btn_run_raw;
  logic       btn_up_raw;
  logic       btn_down_raw;
  logic [3:0] mode;
  logic       step;
  logic       run_led;

  modport master (
    output btn_step_raw, btn_run_raw,
    output btn_up_raw, btn_down_raw,
    input  mode, step, run_led
  );

  modport slave (
    input  btn_step_raw, btn_run_raw,
    input  btn_up_raw, btn_down_raw,
    output mode, step, run_led
  );
endinterface

// File: rtl/button_debouncer.sv
// 2-FF synchronizer, stability counter and rising-edge press pulse
// for one raw push-button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // Flip on the cycle the count would reach DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync0   <= raw;
      r_sync1   <= r_sync0;
      r_level_q <= r_level;
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_level & ~r_level_q;

endmodule

// File: rtl/front_panel_ctrl.sv
// Front-panel conditioner: run/halt FSM, saturating speed register
// and re-armable step level for the CPU clock controller.
module front_panel_ctrl
  import front_panel_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 100000,
  parameter logic [2:0] RESET_SPEED     = SPEED_10HZ
) (
  input  logic              clk,
  input  logic              rst_n,
  front_panel_ctrl_if.slave bus
);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_lvl;
  logic [NUM_BTN-1:0] w_prs;

  assign w_raw[BTN_STEP] = bus.btn_step_raw;
  assign w_raw[BTN_RUN]  = bus.btn_run_raw;
  assign w_raw[BTN_UP]   = bus.btn_up_raw;
  assign w_raw[BTN_DOWN] = bus.btn_down_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (w_raw[i]),
      .level(w_lvl[i]),
      .press(w_prs[i])
    );
  end

  logic w_unused;
  assign w_unused = ^{w_lvl[BTN_DOWN:BTN_RUN], w_prs[BTN_STEP]};

  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_speed;
  logic [2:0] w_speed_nxt;
  logic       r_armed;
  logic       w_armed_nxt;
  logic       r_step;
  logic       w_step_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HALT;
      r_speed <= RESET_SPEED;
      r_armed <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_speed <= w_speed_nxt;
      r_armed <= w_armed_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_speed;
    w_armed_nxt = r_armed;
    w_step_nxt  = 1'b0;

    if (w_prs[BTN_RUN]) begin
      w_state_nxt = (r_state == HALT) ? RUN : HALT;
    end

    w_speed_nxt = speed_next(r_speed, w_prs[BTN_UP],
                             w_prs[BTN_DOWN]);

    // A button still held on halt entry must be released first.
    if (r_state == RUN && w_state_nxt == HALT) begin
      w_armed_nxt = ~w_lvl[BTN_STEP];
    end else if (!w_lvl[BTN_STEP]) begin
      w_armed_nxt = 1'b1;
    end

    w_step_nxt = w_lvl[BTN_STEP] & w_armed_nxt
               & (w_state_nxt == HALT);
  end

  assign bus.mode    = {r_state == RUN, r_speed};
  assign bus.run_led = (r_state == RUN);
  assign bus.step    = r_step;

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Directed + random bench for front_panel_ctrl, checked against a
// window-based behavioural model of the panel.
module tb_front_panel_ctrl;
  import front_panel_pkg::*;

  localparam int DC   = 4;
  localparam int HMAX = 8191;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  front_panel_ctrl_if bus ();

  assign bus.btn_step_raw = raw[0];
  assign bus.btn_run_raw  = raw[1];
  assign bus.btn_up_raw   = raw[2];
  assign bus.btn_down_raw = raw[3];

  front_panel_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .RESET_SPEED    (3'd1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Behavioural model: a button is accepted once its last DC-1
  // synchronized samples all disagree with the accepted level.
  bit hist [4][0:HMAX];
  int k;
  bit lvl  [4];
  bit rose [4];
  bit running;
  int speed;
  bit blocked;
  bit step_m;

  int step_seen;
  int min_seen;

  function automatic bit samp(int b, int i);
    if (i < 1) return 1'b0;
    return hist[b][i];
  endfunction

  task automatic model_reset();
    k = 0;
    for (int b = 0; b < 4; b++) begin
      lvl[b]  = 1'b0;
      rose[b] = 1'b0;
    end
    running = 1'b0;
    speed   = 1;
    blocked = 1'b0;
    step_m  = 1'b0;
  endtask

  task automatic model_edge();
    bit was_run;
    bit diff;
    if (k < HMAX) k++;
    for (int b = 0; b < 4; b++) hist[b][k] = raw[b];
    was_run = running;
    if (rose[1]) running = !running;
    if (rose[2] && !rose[3]) speed = (speed < 7) ? speed + 1 : 7;
    else if (rose[3] && !rose[2]) speed = (speed > 1) ? speed - 1 : 1;
    if (was_run && !running) blocked = lvl[0];
    else if (!lvl[0]) blocked = 1'b0;
    step_m = lvl[0] && !blocked && !running;
    for (int b = 0; b < 4; b++) begin
      diff = 1'b1;
      for (int j = k - DC; j <= k - 2; j++)
        if (samp(b, j) == lvl[b]) diff = 1'b0;
      rose[b] = 1'b0;
      if (diff) begin
        lvl[b]  = !lvl[b];
        rose[b] = lvl[b];
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [5:0] obs;
    logic [5:0] exp;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    obs = {bus.mode, bus.step, bus.run_led};
    exp = {running, 3'(speed), step_m, running};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL cycle_model t=%0t observed=%b expected=%b",
             $time, obs, exp);
    end
    if (bus.step) step_seen++;
    if (int'(bus.mode[2:0]) < min_seen) min_seen = int'(bus.mode[2:0]);
  endtask

  task automatic press(logic [3:0] m);
    raw = raw | m;
    repeat (8) tick();
    raw = raw & ~m;
    repeat (8) tick();
  endtask

  int rise;
  int fall;
  int hold;

  initial begin
    raw       = 4'b0000;
    step_seen = 0;
    min_seen  = 7;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mode", int'(bus.mode), 1);
    chk("reset_step", int'(bus.step), 0);
    chk("reset_led", int'(bus.run_led), 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Step latency, press and release
    raw[0] = 1'b1;
    rise = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.step && rise == 0) rise = i;
    end
    chk("step_rise", rise, 6);
    raw[0] = 1'b0;
    fall = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (!bus.step && fall == 0) fall = i;
    end
    chk("step_fall", fall, 6);

    // Bouncing step input never accepted
    step_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) raw[0] = ~raw[0];
      tick();
    end
    raw[0] = 1'b0;
    repeat (8) tick();
    chk("bounce_step", step_seen, 0);

    // Speed saturation
    repeat (8) press(4'b0100);
    chk("speed_max", int'(bus.mode[2:0]), 7);
    min_seen = 7;
    repeat (10) press(4'b1000);
    chk("speed_min", int'(bus.mode[2:0]), 1);
    chk("speed_never0", min_seen, 1);

    // Run toggle with step held
    raw[0] = 1'b1;
    repeat (8) tick();
    chk("step_held_halt", int'(bus.step), 1);
    press(4'b0010);
    chk("run_mode", int'(bus.mode), 9);
    chk("run_step0", int'(bus.step), 0);
    step_seen = 0;
    press(4'b0010);
    chk("halt_mode", int'(bus.mode), 1);
    raw[0] = 1'b0;
    repeat (8) tick();
    chk("held_no_step", step_seen, 0);
    raw[0] = 1'b1;
    repeat (8) tick();
    chk("repress_step", int'(bus.step), 1);
    raw[0] = 1'b0;
    repeat (8) tick();

    // Simultaneous up/down
    press(4'b0100);
    press(4'b1100);
    chk("updown_cancel", int'(bus.mode[2:0]), 2);

    // Simultaneous run/step in halt
    step_seen = 0;
    press(4'b0011);
    chk("runstep_run", int'(bus.mode[3]), 1);
    chk("runstep_nostep", step_seen, 0);

    // Random button activity with bounces
    for (int n = 0; n < 80; n++) begin
      raw  = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 9);
      repeat (hold) tick();
    end
    raw = 4'b0000;
    repeat (10) tick();

    // Reset mid-operation, pending up press discarded
    if (!running) press(4'b0010);
    if (speed == 1) press(4'b0100);
    chk("pre_reset_run", int'(bus.run_led), 1);
    raw[2] = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mode", int'(bus.mode), 1);
    chk("async_reset_step", int'(bus.step), 0);
    chk("async_reset_led", int'(bus.run_led), 0);
    model_reset();
    raw = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) tick();
    chk("post_reset_speed", int'(bus.mode), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/front_panel_ctrl.md
# front_panel_ctrl

Front-panel input conditioner that drives the `mode[3:0]` and `step` inputs of the CPU clock controller. It synchronizes and debounces four raw push-buttons (step, run/halt, faster, slower). It keeps the run/halt state and the speed selection. It presents clean, glitch-free levels so the clock controller's edge detector sees exactly one rising `step` edge per physical press.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required to accept a button change (10 ms at 10 MHz); minimum 2.
- `RESET_SPEED`, default 3'd1: speed code loaded at reset (10 Hz); legal range 1..7.
- `clk`  in  1  10 MHz system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `btn_step_raw`  in  1  raw step button, asynchronous, active-high.
- `btn_run_raw`  in  1  raw run/halt toggle button, asynchronous, active-high.
- `btn_up_raw`  in  1  raw "faster" button, asynchronous, active-high.
- `btn_down_raw`  in  1  raw "slower" button, asynchronous, active-high.
- `mode`  out  4  `{running, speed[2:0]}` to the clock controller.
- `step`  out  1  clean step level to the clock controller; may be high only while halted.
- `run_led`  out  1  equals `mode[3]`.

## Operation
- **Button conditioning** (per button):
  - The raw input passes through a 2-FF synchronizer.
  - A debounce counter runs while the synchronized value differs from the accepted state. It clears to 0 whenever the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while they still differ, the accepted state flips and the counter clears.
  - A press pulse (1 cycle) is generated on an accepted 0→1 transition.
- **State machine:** HALT, RUN.
  - A `run` press toggles HALT↔RUN.
  - `mode[3]` = 1 in RUN, 0 in HALT.
- **Speed register** (3 bits):
  - An `up` press increments, saturating at 7.
  - A `down` press decrements, saturating at 1. Code 0 is never produced.
  - Speed changes are accepted in both states. `mode[2:0]` always shows the speed register.
- **Step output:**
  - `step` = accepted step state AND `armed` AND state==HALT.
  - `armed` clears on entry to HALT. It sets when the accepted step state is 0.
  - Effect: a step button held down across RUN→HALT produces no edge until it is released and pressed again.
- **Simultaneous events:**
  - `up` and `down` press in the same cycle: speed unchanged.
  - `run` and `step` press in the same cycle while in HALT: go to RUN and hold `step` at 0.
  - `run` press at the same time as `up`/`down`: both take effect.
- **Reset (asynchronous assert):**
  - State = HALT, speed = `RESET_SPEED`, so `mode` = `{1'b0, RESET_SPEED}`.
  - `step` = 0, `run_led` = 0, `armed` = 0.
  - All synchronizer flops, accepted states and counters = 0.
  - Reset asserted mid-debounce discards the pending change.

## Timing
- Raw level change stable from cycle 0:
  - Synchronized value differs at edge 2.
  - Accepted state flips at edge 2+`DEBOUNCE_CYCLES`-1.
  - Press pulse is combinational from the flip.
  - `mode`/`step` registers update at the next edge: total latency `DEBOUNCE_CYCLES`+2 cycles.
- A bounce (synchronized value returning to the accepted state) at any point restarts the count from 0.
- Release is debounced identically. `step` falls `DEBOUNCE_CYCLES`+2 cycles after a stable raw release.
- All outputs are registered. No combinational path from any raw input to any output.
- Deassertion of `rst_n` is synchronous to `clk` through the integration-level reset synchronizer. This block does not resynchronize it.

## Structure
- **Shared package `front_panel_pkg`:**
  - State enum (HALT=0, RUN=1).
  - Speed-code localparams matching the clock controller's mode encoding: 1=10 Hz … 6=1 MHz, 7=turbo.
  - `SPEED_MIN`=1, `SPEED_MAX`=7.
- **Sub-module `button_debouncer`:**
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports `clk`, `rst_n`, `raw`, `level`, `press`.
  - Contains the synchronizer, counter (width `$clog2(DEBOUNCE_CYCLES)`) and edge pulse.
  - Instantiated four times.
- **Top level:** FSM, speed register, `armed` flag, output registers.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4.
1. **Reset:** assert `rst_n`=0 mid-operation → `mode`=4'b0001, `step`=0, `run_led`=0 immediately, without waiting for a clock edge.
2. **Step latency:** in HALT, hold `btn_step_raw`=1 for 20 cycles → `step` rises exactly 6 cycles after the raw rise and falls 6 cycles after the raw release. Toggling the raw input every 2 cycles for 30 cycles → `step` stays 0.
3. **Speed saturation:** 8 `up` presses → `mode[2:0]`=7. Then 10 `down` presses → `mode[2:0]`=1, never 0.
4. **Run toggle:** a `run` press → `mode`=4'b1001 with `step` forced 0 even while the step button is held. A second press → HALT, and `step` stays 0 until the button is released and re-pressed.
5. **Simultaneous up/down:** `up` and `down` pressed with identical timing → speed unchanged.
6. **Simultaneous run/step:** `run` and `step` pressed with identical timing in HALT → RUN entered, and `step` never pulses.
